interrupt_stack_ctrl: RTL and testbench

- Interrupt front-end and return-address stack. Sits directly upstream of control_unit.
- Synchronises external interrupt requests, arbitrates them by priority, and drives the control unit's `int` input.
- Pushes the current PC onto an internal byte stack and issues a vector load to the program counter.
- Services the control unit's RETI pops (pop_1_stack, pop_2_stack) to restore the PC.

---
 rtl/interrupt_stack_ctrl_pkg.sv | 19 +
 rtl/irq_sync_edge.sv | 33 +++
 rtl/interrupt_stack_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_interrupt_stack_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_stack_ctrl_pkg.sv
// Shared definitions for the interrupt front-end / return-address stack.
//   - FSM state encoding (exported on the top's state_dbg port)
//   - default vector placement
//   - stack byte width
package interrupt_stack_ctrl_pkg;

  localparam int BYTE_W = 8;

  localparam logic [15:0] DEF_VEC_BASE   = 16'h0003;
  localparam int          DEF_VEC_STRIDE = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PUSH_LO = 2'd1,
    ST_PUSH_HI = 2'd2,
    ST_VECTOR  = 2'd3
  } state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one active-low asynchronous request, followed by
// a falling-edge detector on the synchronised value.
// Ports:
//   clock    in  system clock
//   reset    in  asynchronous active-low reset (flops return to the idle-high level)
//   irq_n_i  in  raw asynchronous request, active low
//   fall_o   out one-cycle pulse when the synchronised request goes 1 -> 0
// An asynchronous fall is seen on fall_o after two clocks, so the pending bit
// it feeds is set on the third clock.
module irq_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic irq_n_i,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= irq_n_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign fall_o = prev_q & ~s2_q;

endmodule

// File: rtl/interrupt_stack_ctrl.sv
// Interrupt front-end and return-address stack, upstream of control_unit.
// Captures falling edges on irq_n into pending bits, accepts the highest
// priority eligible source (index 0 highest), pushes pc_in onto a byte stack
// (low byte first), then strobes a vector load. RETI pops from control_unit
// rebuild the return PC (high byte first) and retire the innermost service.
// Ports:
//   clock, reset          clock / asynchronous active-low reset
//   irq_n[NUM_SRC]        active-low, falling-edge triggered requests
//   irq_mask[NUM_SRC]     1 = source enabled
//   int_en                control_unit is in a state where accepting is safe
//   pc_in                 return address pushed on accept
//   pop_1_stack/pop_2_stack  RETI first / second pop
//   int_o                 the control unit's "int" input (renamed: int is a
//                         reserved word); high while pushing and vectoring
//   pc_load_vec/pc_vector one-cycle vector load strobe and address
//   pc_ret_load/pc_ret    one-cycle return load strobe and address
//   in_service            sources currently being serviced
//   stack_ovf/stack_unf   sticky overflow / underflow flags
//   state_dbg, sp_dbg     FSM state and stack pointer for observation
// PC_W must be 16: each stack entry is exactly two bytes.
module interrupt_stack_ctrl
  import interrupt_stack_ctrl_pkg::*;
#(
  parameter int               NUM_SRC     = 2,
  parameter int               PC_W        = 16,
  parameter int               STACK_BYTES = 8,
  parameter logic [PC_W-1:0]  VEC_BASE    = DEF_VEC_BASE,
  parameter int               VEC_STRIDE  = DEF_VEC_STRIDE
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_SRC-1:0]                 irq_n,
  input  logic [NUM_SRC-1:0]                 irq_mask,
  input  logic                               int_en,
  input  logic [PC_W-1:0]                    pc_in,
  input  logic                               pop_1_stack,
  input  logic                               pop_2_stack,
  output logic                               int_o,
  output logic                               pc_load_vec,
  output logic [PC_W-1:0]                    pc_vector,
  output logic                               pc_ret_load,
  output logic [PC_W-1:0]                    pc_ret,
  output logic [NUM_SRC-1:0]                 in_service,
  output logic                               stack_ovf,
  output logic                               stack_unf,
  output logic [1:0]                         state_dbg,
  output logic [$clog2(STACK_BYTES+1)-1:0]   sp_dbg
);

  localparam int SP_W  = $clog2(STACK_BYTES + 1);
  localparam int IDX_W = (STACK_BYTES > 1) ? $clog2(STACK_BYTES) : 1;
  localparam int WIN_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);
  localparam logic [SP_W-1:0] SP_TWO     = SP_W'(2);
  // Highest SP at which a full two-byte entry still fits.
  localparam logic [SP_W-1:0] SP_ACC_MAX = SP_W'(STACK_BYTES - 2);

  state_e                 state_q, state_d;
  logic [NUM_SRC-1:0]     pending_q, in_service_q;
  logic [NUM_SRC-1:0]     fall, elig, acc_clr;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [SP_W-1:0]        sp_q, sp_m1;
  logic [BYTE_W-1:0]      stack_q [STACK_BYTES];
  logic [PC_W-1:0]        pc_ret_q, vec_addr;
  logic                   ret_load_q, ovf_q, unf_q;
  logic                   blocked, any_elig, in_idle, pop_any, room;
  logic                   accept, ovf_hit, pop1_ok, pop2_ok, unf_hit;

  // ---------------------------------------------------------------- capture
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clock   (clock),
      .reset   (reset),
      .irq_n_i (irq_n[g]),
      .fall_o  (fall[g])
    );
  end

  // ------------------------------------------------------------ arbitration
  // A source may preempt only if its index is below every in-service index,
  // so "blocked" accumulates in_service from index 0 up to and including i.
  always_comb begin
    elig     = '0;
    blocked  = 1'b0;
    win_d    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      blocked = blocked | in_service_q[i];
      elig[i] = pending_q[i] & irq_mask[i] & ~blocked;
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_d = WIN_W'(i);
    end
    any_elig = |elig;
  end

  assign in_idle = (state_q == ST_IDLE);
  // A pop in IDLE wins over an accept in the same cycle.
  assign pop_any = in_idle & (pop_1_stack | pop_2_stack);
  assign room    = (sp_q <= SP_ACC_MAX);
  assign accept  = in_idle & ~pop_any & int_en & any_elig & room;
  assign ovf_hit = in_idle & ~pop_any & int_en & any_elig & ~room;
  // If both pops are raised together the first pop is taken.
  assign pop1_ok = in_idle & pop_1_stack & (sp_q >= SP_TWO);
  assign pop2_ok = in_idle & ~pop_1_stack & pop_2_stack & (sp_q >= SP_ONE);
  assign unf_hit = in_idle & ((pop_1_stack & (sp_q < SP_TWO)) |
                              (~pop_1_stack & pop_2_stack & (sp_q == '0)));
  assign acc_clr = accept ? (NUM_SRC'(1) << win_d) : '0;
  assign sp_m1   = sp_q - SP_ONE;
  assign vec_addr = VEC_BASE + PC_W'(win_q) * PC_W'(VEC_STRIDE);

  // --------------------------------------------------------- FSM: register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_PUSH_LO;
      ST_PUSH_LO: state_d = ST_PUSH_HI;
      ST_PUSH_HI: state_d = ST_VECTOR;
      ST_VECTOR:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- FSM: outputs
  always_comb begin
    int_o       = 1'b0;
    pc_load_vec = 1'b0;
    pc_vector   = '0;
    case (state_q)
      ST_PUSH_LO, ST_PUSH_HI: int_o = 1'b1;
      ST_VECTOR: begin
        int_o       = 1'b1;
        pc_load_vec = 1'b1;
        pc_vector   = vec_addr;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q    <= '0;
      in_service_q <= '0;
      win_q        <= '0;
      sp_q         <= '0;
      pc_ret_q     <= '0;
      ret_load_q   <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      for (int i = 0; i < STACK_BYTES; i++) stack_q[i] <= '0;
    end else begin
      // A new edge on an already-pending source simply merges into the bit.
      pending_q  <= (pending_q | fall) & ~acc_clr;
      ret_load_q <= pop2_ok;
      ovf_q      <= ovf_q | ovf_hit;
      unf_q      <= unf_q | unf_hit;
      if (accept) win_q <= win_d;

      case (state_q)
        ST_PUSH_LO: begin
          stack_q[sp_q[IDX_W-1:0]] <= pc_in[BYTE_W-1:0];
          sp_q <= sp_q + SP_ONE;
        end
        ST_PUSH_HI: begin
          stack_q[sp_q[IDX_W-1:0]] <= pc_in[2*BYTE_W-1:BYTE_W];
          sp_q <= sp_q + SP_ONE;
        end
        ST_VECTOR: in_service_q[win_q] <= 1'b1;
        default: begin
          if (pop1_ok) begin
            sp_q <= sp_m1;
            pc_ret_q[2*BYTE_W-1:BYTE_W] <= stack_q[sp_m1[IDX_W-1:0]];
          end else if (pop2_ok) begin
            sp_q <= sp_m1;
            pc_ret_q[BYTE_W-1:0] <= stack_q[sp_m1[IDX_W-1:0]];
            // Retire the innermost (highest priority) active service.
            in_service_q <= in_service_q & (in_service_q - NUM_SRC'(1));
          end
        end
      endcase
    end
  end

  assign pc_ret_load = ret_load_q;
  assign pc_ret      = pc_ret_q;
  assign in_service  = in_service_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;
  assign state_dbg   = state_q;
  assign sp_dbg      = sp_q;

endmodule

// File: tb/tb_interrupt_stack_ctrl.sv
// Directed bench: one 8-byte-stack instance for service, nesting, gating,
// underflow and reset; one 2-byte-stack instance for overflow.
module tb_interrupt_stack_ctrl;

  // ------------------------------------------------------ clock and reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------- instance A
  logic [1:0]  irq_n_a = 2'b11, mask_a = 2'b11;
  logic        int_en_a = 1'b1, pop1_a = 1'b0, pop2_a = 1'b0;
  logic [15:0] pc_in_a = 16'h1234;
  logic        int_a, vld_a, rld_a, ovf_a, unf_a;
  logic [15:0] vec_a, ret_a;
  logic [1:0]  ins_a, st_a;
  logic [3:0]  sp_a;

  interrupt_stack_ctrl #(.STACK_BYTES(8)) dut_a (
    .clock(clock), .reset(reset), .irq_n(irq_n_a), .irq_mask(mask_a),
    .int_en(int_en_a), .pc_in(pc_in_a), .pop_1_stack(pop1_a), .pop_2_stack(pop2_a),
    .int_o(int_a), .pc_load_vec(vld_a), .pc_vector(vec_a), .pc_ret_load(rld_a),
    .pc_ret(ret_a), .in_service(ins_a), .stack_ovf(ovf_a), .stack_unf(unf_a),
    .state_dbg(st_a), .sp_dbg(sp_a)
  );

  // ---------------------------------------------------------- instance B
  logic [1:0]  irq_n_b = 2'b11, mask_b = 2'b11;
  logic        int_en_b = 1'b1, pop1_b = 1'b0, pop2_b = 1'b0;
  logic [15:0] pc_in_b = 16'h5555;
  logic        int_b, vld_b, rld_b, ovf_b, unf_b;
  logic [15:0] vec_b, ret_b;
  logic [1:0]  ins_b, st_b;
  logic [1:0]  sp_b;

  interrupt_stack_ctrl #(.STACK_BYTES(2)) dut_b (
    .clock(clock), .reset(reset), .irq_n(irq_n_b), .irq_mask(mask_b),
    .int_en(int_en_b), .pc_in(pc_in_b), .pop_1_stack(pop1_b), .pop_2_stack(pop2_b),
    .int_o(int_b), .pc_load_vec(vld_b), .pc_vector(vec_b), .pc_ret_load(rld_b),
    .pc_ret(ret_b), .in_service(ins_b), .stack_ovf(ovf_b), .stack_unf(unf_b),
    .state_dbg(st_b), .sp_dbg(sp_b)
  );

  // ----------------------------------------------------------- scoreboard
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for int on instance A; n = clocks taken.
  task automatic wait_int(input string tag, output int n);
    n = 0;
    while (int_a !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, int_a}, 32'd1);
  endtask

  // RETI on instance A: first pop, then second pop; ends with pc_ret_load high.
  task automatic reti();
    pop1_a = 1'b1;
    tick();
    pop1_a = 1'b0;
    pop2_a = 1'b1;
    tick();
    pop2_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------- directed sequence
  initial begin
    int n;
    #1;
    chk("rst_int",      {31'd0, int_a}, 32'd0);
    chk("rst_vld",      {31'd0, vld_a}, 32'd0);
    chk("rst_vec",      {16'd0, vec_a}, 32'd0);
    chk("rst_ret",      {16'd0, ret_a}, 32'd0);
    chk("rst_rld",      {31'd0, rld_a}, 32'd0);
    chk("rst_ins",      {30'd0, ins_a}, 32'd0);
    chk("rst_flags",    {30'd0, ovf_a, unf_a}, 32'd0);
    chk("rst_sp",       {28'd0, sp_a}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();

    // Basic service of source 1 and return.
    irq_n_a = 2'b01;
    wait_int("t1_int", n);
    chk("t1_latency", n, 32'd4);
    chk("t1_sp_lo", {28'd0, sp_a}, 32'd0);
    tick();
    chk("t1_int_hi", {31'd0, int_a}, 32'd1);
    chk("t1_sp_hi",  {28'd0, sp_a}, 32'd1);
    tick();
    chk("t1_vld", {31'd0, vld_a}, 32'd1);
    chk("t1_vec", {16'd0, vec_a}, 32'h000B);
    chk("t1_sp2", {28'd0, sp_a}, 32'd2);
    tick();
    chk("t1_int_off", {31'd0, int_a}, 32'd0);
    chk("t1_ins", {30'd0, ins_a}, 32'd2);
    irq_n_a = 2'b11;
    reti();
    chk("t1_rld", {31'd0, rld_a}, 32'd1);
    chk("t1_ret", {16'd0, ret_a}, 32'h1234);
    chk("t1_sp0", {28'd0, sp_a}, 32'd0);
    chk("t1_ins0", {30'd0, ins_a}, 32'd0);
    tick();
    chk("t1_rld_pulse", {31'd0, rld_a}, 32'd0);
    chk("t1_unf", {31'd0, unf_a}, 32'd0);

    // Simultaneous requests: source 0 first, source 1 after RETI.
    repeat (3) tick();
    pc_in_a = 16'h2000;
    irq_n_a = 2'b00;
    wait_int("t2_int0", n);
    repeat (2) tick();
    chk("t2_vec0", {16'd0, vec_a}, 32'h0003);
    tick();
    chk("t2_ins0", {30'd0, ins_a}, 32'd1);
    irq_n_a = 2'b11;
    repeat (5) tick();
    chk("t2_src1_held", {31'd0, int_a}, 32'd0);
    reti();
    chk("t2_ret0", {16'd0, ret_a}, 32'h2000);
    chk("t2_ins_clr", {30'd0, ins_a}, 32'd0);
    wait_int("t2_int1", n);
    repeat (2) tick();
    chk("t2_vec1", {16'd0, vec_a}, 32'h000B);
    tick();
    chk("t2_ins1", {30'd0, ins_a}, 32'd2);
    reti();
    chk("t2_ret1", {16'd0, ret_a}, 32'h2000);
    chk("t2_ins_end", {30'd0, ins_a}, 32'd0);

    // Nesting: source 0 preempts source 1.
    repeat (3) tick();
    pc_in_a = 16'h1111;
    irq_n_a = 2'b01;
    wait_int("t3_int1", n);
    repeat (3) tick();
    chk("t3_ins1", {30'd0, ins_a}, 32'd2);
    irq_n_a = 2'b11;
    repeat (4) tick();
    pc_in_a = 16'h2222;
    irq_n_a = 2'b10;
    wait_int("t3_int0", n);
    repeat (2) tick();
    chk("t3_vec0", {16'd0, vec_a}, 32'h0003);
    chk("t3_sp4", {28'd0, sp_a}, 32'd4);
    tick();
    chk("t3_ins11", {30'd0, ins_a}, 32'd3);
    irq_n_a = 2'b11;
    reti();
    chk("t3_ret_a", {16'd0, ret_a}, 32'h2222);
    chk("t3_ins10", {30'd0, ins_a}, 32'd2);
    chk("t3_sp2", {28'd0, sp_a}, 32'd2);
    tick();
    reti();
    chk("t3_ret_b", {16'd0, ret_a}, 32'h1111);
    chk("t3_ins00", {30'd0, ins_a}, 32'd0);
    chk("t3_sp0", {28'd0, sp_a}, 32'd0);

    // Gating by int_en, then by mask.
    repeat (3) tick();
    int_en_a = 1'b0;
    irq_n_a  = 2'b10;
    repeat (6) tick();
    chk("t4_en_gate", {31'd0, int_a}, 32'd0);
    irq_n_a  = 2'b11;
    int_en_a = 1'b1;
    wait_int("t4_en_release", n);
    chk("t4_en_latency", n, 32'd1);
    repeat (2) tick();
    chk("t4_vec_en", {16'd0, vec_a}, 32'h0003);
    tick();
    reti();
    chk("t4_ins_en", {30'd0, ins_a}, 32'd0);
    mask_a  = 2'b10;
    irq_n_a = 2'b10;
    repeat (6) tick();
    chk("t4_mask_gate", {31'd0, int_a}, 32'd0);
    irq_n_a = 2'b11;
    mask_a  = 2'b11;
    wait_int("t4_mask_release", n);
    repeat (2) tick();
    chk("t4_vec_mask", {16'd0, vec_a}, 32'h0003);
    tick();
    reti();
    chk("t4_ins_mask", {30'd0, ins_a}, 32'd0);

    // Underflow: pop_1 at SP = 0.
    tick();
    pop1_a = 1'b1;
    tick();
    pop1_a = 1'b0;
    chk("t5_unf", {31'd0, unf_a}, 32'd1);
    chk("t5_no_rld", {31'd0, rld_a}, 32'd0);
    chk("t5_sp", {28'd0, sp_a}, 32'd0);

    // Overflow on the 2-byte stack: nested request is refused.
    irq_n_b = 2'b01;
    repeat (8) tick();
    chk("t5b_ins", {30'd0, ins_b}, 32'd2);
    chk("t5b_sp", {30'd0, sp_b}, 32'd2);
    irq_n_b = 2'b11;
    repeat (4) tick();
    irq_n_b = 2'b10;
    repeat (6) tick();
    chk("t5b_no_int", {31'd0, int_b}, 32'd0);
    chk("t5b_ovf", {31'd0, ovf_b}, 32'd1);
    chk("t5b_ins_hold", {30'd0, ins_b}, 32'd2);
    chk("t5_ovf_a", {31'd0, ovf_a}, 32'd0);

    // Reset during PUSH_HI, with source 0 left pending behind a mask.
    repeat (3) tick();
    pc_in_a = 16'hABCD;
    mask_a  = 2'b10;
    irq_n_a = 2'b00;
    wait_int("t6_int", n);
    tick();
    chk("t6_push_hi", {30'd0, st_a}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("t6_int_rst", {31'd0, int_a}, 32'd0);
    chk("t6_vld_rst", {31'd0, vld_a}, 32'd0);
    chk("t6_sp_rst", {28'd0, sp_a}, 32'd0);
    chk("t6_unf_rst", {31'd0, unf_a}, 32'd0);
    irq_n_a = 2'b11;
    mask_a  = 2'b11;
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("t6_pending_clr", {31'd0, int_a}, 32'd0);
    chk("t6_ins_clr", {30'd0, ins_a}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
